// File: rtl/cp0_vec_pkg.sv
// Shared constants for the vectored CP0: register addresses, exception codes
// and the SR/Cause field positions used by the register file and its readers.
package cp0_vec_pkg;

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int IM_LSB       = 10;
    localparam int CAUSE_BD_BIT = 31;
    localparam int EXCCODE_LSB  = 2;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with a sticky match flag that is
// cleared only by a write to Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        flag_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;

    // A Compare write clears the flag even when the match happens in the same cycle
    always_comb begin
        count_d   = count_we_i ? wdata_i : count_q + 32'd1;
        compare_d = compare_we_i ? wdata_i : compare_q;
        flag_d    = flag_q;
        if (compare_we_i) begin
            flag_d = 1'b0;
        end else if (count_q == compare_q) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            flag_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            flag_q    <= flag_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign flag_o    = flag_q;

endmodule

// File: rtl/cp0_vec.sv
// E-stage coprocessor 0 with configurable interrupt lines, optional vectored
// interrupt dispatch and an internal Count/Compare timer interrupt.
module cp0_vec
    import cp0_vec_pkg::*;
#(
    parameter int          NUM_HWINT   = 3,
    parameter logic [31:0] EXC_BASE    = 32'h0000_4180,
    parameter int          VECTORED    = 0,
    parameter logic [31:0] VEC_SPACING = 32'h20,
    parameter logic [31:0] PRID        = 32'h2022_0707
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exl_clr,
    output logic [31:0]          epc_out,
    output logic                 req,
    output logic [31:0]          handler_pc,
    output logic                 exl_out,
    output logic                 timer_int
);

    localparam int IW = NUM_HWINT + 1;

    logic          ie_q, exl_q, bd_q;
    logic [IW-1:0] im_q, ip_q;
    logic [4:0]    exccode_q;
    logic [31:0]   epc_q;

    logic [IW-1:0] ip_live, pending;
    logic          int_p, exc_p, req_w, wr_ok, timer_flag;
    logic [31:0]   vec_idx, epc_target, sr_view, cause_view, count, compare;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .count_we_i   (wr_ok && cp0_addr == ADDR_COUNT),
        .compare_we_i (wr_ok && cp0_addr == ADDR_COMPARE),
        .wdata_i      (cp0_wdata),
        .count_o      (count),
        .compare_o    (compare),
        .flag_o       (timer_flag)
    );

    assign ip_live    = {timer_flag, hw_int};
    assign pending    = ip_live & im_q;
    assign int_p      = (|pending) & ie_q & ~exl_q;
    assign exc_p      = (exc_code != 5'd0) & ~exl_q;
    assign req_w      = (int_p | exc_p) & ~reset;
    assign wr_ok      = we & ~req_w;
    assign epc_target = (bd_in ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;

    // Ascending scan so the highest-index pending line (the timer) wins
    always_comb begin
        vec_idx = 32'd0;
        for (int i = 0; i < IW; i++) begin
            if (pending[i]) vec_idx = 32'(i + 1);
        end
        handler_pc = (VECTORED != 0 && int_p) ? EXC_BASE + VEC_SPACING * vec_idx : EXC_BASE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            bd_q      <= 1'b0;
            im_q      <= '0;
            ip_q      <= '0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            ip_q <= ip_live;
            if (req_w) begin
                exl_q     <= 1'b1;
                bd_q      <= bd_in;
                exccode_q <= int_p ? EXC_INT : exc_code;
                epc_q     <= epc_target;
            end else begin
                if (exl_clr) begin
                    exl_q <= 1'b0;
                end else if (wr_ok && cp0_addr == ADDR_SR) begin
                    exl_q <= cp0_wdata[SR_EXL_BIT];
                end
                if (wr_ok && cp0_addr == ADDR_SR) begin
                    ie_q <= cp0_wdata[SR_IE_BIT];
                    im_q <= cp0_wdata[IM_LSB +: IW];
                end
                if (wr_ok && cp0_addr == ADDR_EPC) begin
                    epc_q <= {cp0_wdata[31:2], 2'b00};
                end
            end
        end
    end

    // Reads show pre-write state; bits without a field read as zero
    always_comb begin
        sr_view                          = 32'd0;
        sr_view[SR_IE_BIT]               = ie_q;
        sr_view[SR_EXL_BIT]              = exl_q;
        sr_view[IM_LSB +: IW]            = im_q;
        cause_view                       = 32'd0;
        cause_view[CAUSE_BD_BIT]         = bd_q;
        cause_view[IM_LSB +: IW]         = ip_q;
        cause_view[EXCCODE_LSB +: 5]     = exccode_q;
        case (cp0_addr)
            ADDR_COUNT:   cp0_rdata = count;
            ADDR_COMPARE: cp0_rdata = compare;
            ADDR_SR:      cp0_rdata = sr_view;
            ADDR_CAUSE:   cp0_rdata = cause_view;
            ADDR_EPC:     cp0_rdata = epc_q;
            ADDR_PRID:    cp0_rdata = PRID;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign req       = req_w;
    assign epc_out   = epc_q;
    assign exl_out   = exl_q;
    assign timer_int = timer_flag;

endmodule
